bp_me_block_mem: RTL and testbench

Block-granular memory endpoint directly downstream of the ME top's CCE-MEM interface. Consumes the mem_cmd channel (block reads) and the mem_data_cmd channel (block writebacks) and services one transaction at a time against an internal block array after a fixed latency. Returns mem_data_resp for reads and mem_resp (write ack) for writebacks. Serves as the memory model for single-CCE ME integration tests.

---
 rtl/bp_me_block_mem.sv | 193 +++++++++++++++++++
 tb/tb_bp_me_block_mem.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_block_mem.sv
// bp_me_block_mem
//
// Block-granular memory endpoint that sits below the ME top's CCE-MEM
// interface. It takes block reads on mem_cmd and block writebacks on
// mem_data_cmd, serves one transaction at a time against an internal block
// array, and answers after a fixed latency. Reads answer on mem_data_resp and
// writebacks answer on mem_resp (write ack).
//
// Ports
//   clk_i, reset_n_i         clock, synchronous active-low reset
//   mem_cmd_*                read command: valid, block address, payload, yumi
//   mem_data_cmd_*           writeback: valid, address, block data, payload, yumi
//   mem_resp_*               write ack: valid, address, payload, ready
//   mem_data_resp_*          read data: valid, address, block data, payload, ready
//
// Optional build macro
//   BP_ME_BLOCK_MEM_ZERO_INIT_EN  After reset, the block runs an INIT walk that
//                                 zeroes one block per cycle across the whole
//                                 array. Both yumis stay low until the walk is
//                                 done. When the macro is undefined, reset goes
//                                 straight to IDLE and the array contents are
//                                 undefined until written.

module bp_me_block_mem #(
    parameter int paddr_width_p   = 22,
    parameter int block_width_p   = 512,
    parameter int num_blocks_p    = 1024,
    parameter int payload_width_p = 16,
    parameter int latency_p       = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       mem_cmd_v_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    output logic                       mem_cmd_yumi_o,

    input  logic                       mem_data_cmd_v_i,
    input  logic [paddr_width_p-1:0]   mem_data_cmd_addr_i,
    input  logic [block_width_p-1:0]   mem_data_cmd_data_i,
    input  logic [payload_width_p-1:0] mem_data_cmd_payload_i,
    output logic                       mem_data_cmd_yumi_o,

    output logic                       mem_resp_v_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    input  logic                       mem_resp_ready_i,

    output logic                       mem_data_resp_v_o,
    output logic [paddr_width_p-1:0]   mem_data_resp_addr_o,
    output logic [block_width_p-1:0]   mem_data_resp_data_o,
    output logic [payload_width_p-1:0] mem_data_resp_payload_o,
    input  logic                       mem_data_resp_ready_i
);

    localparam int offset_w_lp = $clog2(block_width_p / 8);
    localparam int index_w_lp  = (num_blocks_p > 1) ? $clog2(num_blocks_p) : 1;
    localparam int cnt_w_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;

    typedef enum logic [1:0] {
        e_idle,
        e_wait,
        e_resp,
        e_init
    } state_e;

    // With a single-cycle latency the WAIT state is skipped entirely.
    localparam state_e accept_state_lp = (latency_p == 1) ? e_resp : e_wait;

    state_e                     state_r, state_n;
    logic [cnt_w_lp-1:0]        cnt_r, cnt_n;
    logic                       kind_wr_r;
    logic [paddr_width_p-1:0]   addr_r;
    logic [payload_width_p-1:0] payload_r;
    logic [block_width_p-1:0]   rdata_r;

    logic [block_width_p-1:0]   mem_r [num_blocks_p];

    // Offset bits within a block and address bits above the array are
    // dropped, so out-of-range addresses wrap onto the array.
    logic [index_w_lp-1:0]      wr_index, rd_index;
    assign wr_index = mem_data_cmd_addr_i[offset_w_lp +: index_w_lp];
    assign rd_index = mem_cmd_addr_i[offset_w_lp +: index_w_lp];

`ifdef BP_ME_BLOCK_MEM_ZERO_INIT_EN
    logic [index_w_lp-1:0]      init_ptr_r;
`endif

    // Next-state and handshake logic. Yumi is held low while reset is
    // asserted so nothing is consumed by a cycle that is about to be wiped.
    always_comb begin
        state_n             = state_r;
        cnt_n               = cnt_r;
        mem_cmd_yumi_o      = 1'b0;
        mem_data_cmd_yumi_o = 1'b0;
        case (state_r)
            e_idle: begin
                if (reset_n_i) begin
                    // Writeback has priority so a read queued behind it
                    // observes the new data.
                    if (mem_data_cmd_v_i) begin
                        mem_data_cmd_yumi_o = 1'b1;
                        state_n             = accept_state_lp;
                        cnt_n               = cnt_w_lp'(latency_p - 1);
                    end else if (mem_cmd_v_i) begin
                        mem_cmd_yumi_o = 1'b1;
                        state_n        = accept_state_lp;
                        cnt_n          = cnt_w_lp'(latency_p - 1);
                    end
                end
            end
            e_wait: begin
                cnt_n = cnt_r - 1'b1;
                if (cnt_r == cnt_w_lp'(1)) begin
                    state_n = e_resp;
                end
            end
            e_resp: begin
                if ((kind_wr_r && mem_resp_ready_i) || (!kind_wr_r && mem_data_resp_ready_i)) begin
                    state_n = e_idle;
                end
            end
            e_init: begin
`ifdef BP_ME_BLOCK_MEM_ZERO_INIT_EN
                if (init_ptr_r == index_w_lp'(num_blocks_p - 1)) begin
                    state_n = e_idle;
                end
`else
                state_n = e_idle;
`endif
            end
            default: state_n = e_idle;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
`ifdef BP_ME_BLOCK_MEM_ZERO_INIT_EN
            state_r    <= e_init;
            init_ptr_r <= '0;
`else
            state_r    <= e_idle;
`endif
            cnt_r      <= '0;
            kind_wr_r  <= 1'b0;
            addr_r     <= '0;
            payload_r  <= '0;
            rdata_r    <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (mem_data_cmd_yumi_o) begin
                kind_wr_r <= 1'b1;
                addr_r    <= mem_data_cmd_addr_i;
                payload_r <= mem_data_cmd_payload_i;
            end else if (mem_cmd_yumi_o) begin
                kind_wr_r <= 1'b0;
                addr_r    <= mem_cmd_addr_i;
                payload_r <= mem_cmd_payload_i;
                rdata_r   <= mem_r[rd_index];
            end
`ifdef BP_ME_BLOCK_MEM_ZERO_INIT_EN
            if (state_r == e_init) begin
                init_ptr_r <= init_ptr_r + 1'b1;
            end
`endif
        end
    end

    // Block array. It has no reset so committed writes survive a reset.
    always_ff @(posedge clk_i) begin
        if (mem_data_cmd_yumi_o) begin
            mem_r[wr_index] <= mem_data_cmd_data_i;
        end
`ifdef BP_ME_BLOCK_MEM_ZERO_INIT_EN
        else if (reset_n_i && (state_r == e_init)) begin
            mem_r[init_ptr_r] <= '0;
        end
`endif
    end

    assign mem_resp_v_o            = (state_r == e_resp) && kind_wr_r;
    assign mem_resp_addr_o         = addr_r;
    assign mem_resp_payload_o      = payload_r;

    assign mem_data_resp_v_o       = (state_r == e_resp) && !kind_wr_r;
    assign mem_data_resp_addr_o    = addr_r;
    assign mem_data_resp_data_o    = rdata_r;
    assign mem_data_resp_payload_o = payload_r;

endmodule

// File: tb/tb_bp_me_block_mem.sv
module tb_bp_me_block_mem;

    localparam int AW  = 22;
    localparam int BW  = 512;
    localparam int NB  = 1024;
    localparam int PW  = 16;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_v, cmd_yumi;
    logic [AW-1:0] cmd_addr;
    logic [PW-1:0] cmd_payload;
    logic          dc_v, dc_yumi;
    logic [AW-1:0] dc_addr;
    logic [BW-1:0] dc_data;
    logic [PW-1:0] dc_payload;
    logic          resp_v, resp_ready;
    logic [AW-1:0] resp_addr;
    logic [PW-1:0] resp_payload;
    logic          dresp_v, dresp_ready;
    logic [AW-1:0] dresp_addr;
    logic [BW-1:0] dresp_data;
    logic [PW-1:0] dresp_payload;

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per block, with a flag saying whether the
    // content is known.
    logic [BW-1:0] model_mem [NB];
    bit            model_ok  [NB];
    logic [AW-1:0] wr_pool   [$];

    always #5 clk = ~clk;

    bp_me_block_mem #(
        .paddr_width_p  (AW),
        .block_width_p  (BW),
        .num_blocks_p   (NB),
        .payload_width_p(PW),
        .latency_p      (LAT)
    ) dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .mem_cmd_v_i            (cmd_v),
        .mem_cmd_addr_i         (cmd_addr),
        .mem_cmd_payload_i      (cmd_payload),
        .mem_cmd_yumi_o         (cmd_yumi),
        .mem_data_cmd_v_i       (dc_v),
        .mem_data_cmd_addr_i    (dc_addr),
        .mem_data_cmd_data_i    (dc_data),
        .mem_data_cmd_payload_i (dc_payload),
        .mem_data_cmd_yumi_o    (dc_yumi),
        .mem_resp_v_o           (resp_v),
        .mem_resp_addr_o        (resp_addr),
        .mem_resp_payload_o     (resp_payload),
        .mem_resp_ready_i       (resp_ready),
        .mem_data_resp_v_o      (dresp_v),
        .mem_data_resp_addr_o   (dresp_addr),
        .mem_data_resp_data_o   (dresp_data),
        .mem_data_resp_payload_o(dresp_payload),
        .mem_data_resp_ready_i  (dresp_ready)
    );

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    // 64-byte blocks, 1024 of them: block = (addr / 64) mod 1024.
    function automatic int blk(input logic [AW-1:0] a);
        return (int'(a) / 64) % NB;
    endfunction

    function automatic logic [BW-1:0] rep8(input logic [7:0] b);
        return {64{b}};
    endfunction

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < NB; i++) begin
            model_mem[i] = '0;
            model_ok[i]  = 1'b1;
        end
    endtask

    // Present one command and wait for it to be consumed; returns just after
    // the accepting clock edge.
    task automatic accept(input bit is_wr, input logic [AW-1:0] a,
                          input logic [BW-1:0] d, input logic [PW-1:0] p);
        int n;
        n = 0;
        @(negedge clk);
        if (is_wr) begin
            dc_v = 1'b1; dc_addr = a; dc_data = d; dc_payload = p;
        end else begin
            cmd_v = 1'b1; cmd_addr = a; cmd_payload = p;
        end
        #1;
        while (((is_wr ? dc_yumi : cmd_yumi) !== 1'b1) && (n < 20)) begin
            @(negedge clk); #1; n++;
        end
        check("yumi_wait", n, 0);
        check("yumi_other", is_wr ? cmd_yumi : dc_yumi, 0);
        @(posedge clk); #1;
        dc_v  = 1'b0;
        cmd_v = 1'b0;
        if (is_wr) begin
            model_mem[blk(a)] = d;
            model_ok[blk(a)]  = 1'b1;
        end
    endtask

    // Follow one response from the accepting edge through the handshake.
    // With hold set, the caller keeps a read pending so the bench can see
    // that it is not consumed until the block is back in IDLE; on return the
    // pending read's yumi is high and the caller decides whether to take it.
    task automatic wait_resp(input bit is_wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                             input logic [PW-1:0] p, input int bp, input bit hold);
        logic [1:0] exp_v;
        exp_v = is_wr ? 2'b10 : 2'b01;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk); #1;
            if (k < LAT) check("early_valid", {resp_v, dresp_v}, 0);
            if (hold) check("yumi_busy", cmd_yumi, 0);
        end
        for (int j = 0; j <= bp; j++) begin
            if (j > 0) begin
                @(negedge clk); #1;
            end
            check("resp_valid", {resp_v, dresp_v}, exp_v);
            check("resp_addr", is_wr ? resp_addr : dresp_addr, a);
            check("resp_payload", is_wr ? resp_payload : dresp_payload, p);
            if (!is_wr) check("resp_data", dresp_data, d);
            if (hold) check("yumi_in_resp", cmd_yumi, 0);
        end
        if (is_wr) resp_ready = 1'b1;
        else       dresp_ready = 1'b1;
        #1;
        if (hold) check("yumi_hs_cycle", cmd_yumi, 0);
        @(posedge clk); #1;
        resp_ready  = 1'b0;
        dresp_ready = 1'b0;
        @(negedge clk); #1;
        check("valid_after_hs", {resp_v, dresp_v}, 0);
        if (hold) check("yumi_after_ready", cmd_yumi, 1);
    endtask

    task automatic do_txn(input bit is_wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                          input logic [PW-1:0] p, input int bp, input bit hold);
        logic [BW-1:0] exp_d;
        exp_d = is_wr ? d : model_mem[blk(a)];
        accept(is_wr, a, d, p);
        if (hold) begin
            cmd_v = 1'b1; cmd_addr = AW'($urandom); cmd_payload = PW'($urandom);
        end
        wait_resp(is_wr, a, exp_d, p, bp, hold);
        cmd_v = 1'b0;
    endtask

    // After reset release: with zero-init compiled in, the block must refuse
    // commands during the walk and then hold all-zero blocks.
    task automatic after_reset();
`ifdef BP_ME_BLOCK_MEM_ZERO_INIT_EN
        cmd_v = 1'b1; cmd_addr = '0; cmd_payload = '0;
        for (int i = 0; i < NB; i++) begin
            #1;
            check("init_yumi", {cmd_yumi, dc_yumi}, 0);
            @(negedge clk);
        end
        cmd_v = 1'b0;
        model_zero();
        #1;
`endif
    endtask

    // Structural invariants, sampled away from the clock edge.
    always @(negedge clk) begin
        #2;
        check("one_yumi", cmd_yumi & dc_yumi, 0);
        check("one_valid", resp_v & dresp_v, 0);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        reset_n = 1'b0;
        cmd_v = 0; cmd_addr = '0; cmd_payload = '0;
        dc_v = 0; dc_addr = '0; dc_data = '0; dc_payload = '0;
        resp_ready = 0; dresp_ready = 0;
        for (int i = 0; i < NB; i++) model_ok[i] = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_valids", {resp_v, dresp_v}, 0);
        check("rst_yumis", {cmd_yumi, dc_yumi}, 0);
        check("rst_resp_addr", resp_addr, 0);
        check("rst_resp_payload", resp_payload, 0);
        check("rst_dresp_addr", dresp_addr, 0);
        check("rst_dresp_data", dresp_data, 0);
        check("rst_dresp_payload", dresp_payload, 0);
        @(negedge clk);
        reset_n = 1'b1;
        after_reset();

        // Write then read back.
        do_txn(1, 22'h40, rep8(8'hA5), 16'h12, 0, 0);
        do_txn(0, 22'h40, '0, 16'h34, 0, 0);

        // Read and writeback to the same block arrive together.
        @(negedge clk);
        dc_v = 1; dc_addr = 22'h80; dc_data = rep8(8'h3C); dc_payload = 16'h55;
        cmd_v = 1; cmd_addr = 22'h80; cmd_payload = 16'h66;
        #1;
        check("sim_wr_yumi", dc_yumi, 1);
        check("sim_rd_yumi", cmd_yumi, 0);
        @(posedge clk); #1;
        dc_v = 0;
        model_mem[blk(22'h80)] = rep8(8'h3C);
        model_ok[blk(22'h80)]  = 1'b1;
        wait_resp(1, 22'h80, '0, 16'h55, 2, 1);
        @(posedge clk); #1;
        cmd_v = 0;
        wait_resp(0, 22'h80, rep8(8'h3C), 16'h66, 0, 0);

        // Long backpressure on read data with another read pending.
        do_txn(0, 22'h40, '0, 16'h77, 10, 1);

        // Upper address bits alias onto block 0.
        do_txn(1, 22'h10000, rep8(8'h77), 16'h01, 0, 0);
        do_txn(0, 22'h0, '0, 16'h02, 1, 0);

        // Reset two cycles into a read's wait.
        accept(0, 22'h40, '0, 16'h99);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); #1;
        check("midrst_valids", {resp_v, dresp_v}, 0);
        check("midrst_addr", dresp_addr, 0);
        check("midrst_payload", dresp_payload, 0);
        reset_n = 1'b1;
        after_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            check("midrst_no_resp", {resp_v, dresp_v}, 0);
        end
        do_txn(0, 22'h40, '0, 16'h9A, 0, 0);

        // Randomized mix; reads target known blocks, with offset and upper
        // address bits scrambled.
        for (int t = 0; t < 30; t++) begin
            if ((wr_pool.size() == 0) || ($urandom_range(0, 1) == 0)) begin
                a = AW'($urandom);
                d = rand_block();
                wr_pool.push_back(a);
                do_txn(1, a, d, PW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else begin
                a = wr_pool[$urandom_range(0, wr_pool.size() - 1)];
                a = a ^ AW'($urandom_range(0, 63)) ^ (AW'($urandom_range(0, 63)) << 16);
                do_txn(0, a, '0, PW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
